// File: rtl/divider_core.sv
// Sequential restoring divider on the scratch-memory/divider handshake.
//
// Captures a numerator (cdf value) and a denominator (normaliser) on a
// one-cycle read-data-ready strobe. It computes (numerator * SCALE) / denominator
// at one quotient bit per clock, then pulses div_done. The saturated quotient is
// presented on sc_mem_wt_data.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous active-high reset
//   sc_mem_rd_data_rdy  one-cycle strobe, operands valid this cycle
//   sc_mem_rd_data1     numerator operand
//   sc_mem_rd_data2     denominator operand
//   div_done            one-cycle pulse, quotient valid
//   sc_mem_wt_data      saturated quotient, held until the next result
//   div_busy            high from capture edge through the div_done cycle
//   div_by_zero         last completed operation had a zero denominator
//   div_overrun         sticky, a strobe arrived while busy
module divider_core #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SCALE_W = 8,
    parameter int unsigned SCALE   = 255,
    parameter int unsigned QUOT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sc_mem_rd_data_rdy,
    input  logic [DATA_W-1:0] sc_mem_rd_data1,
    input  logic [DATA_W-1:0] sc_mem_rd_data2,
    output logic              div_done,
    output logic [QUOT_W-1:0] sc_mem_wt_data,
    output logic              div_busy,
    output logic              div_by_zero,
    output logic              div_overrun
);

    localparam int unsigned NW   = DATA_W + SCALE_W;
    localparam int unsigned CntW = $clog2(NW + 1);

    localparam logic [NW-1:0]   ScaleExt = NW'(SCALE);
    localparam logic [CntW-1:0] LastIter = CntW'(NW - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [NW-1:0]     num_q, num_d;
    logic [NW-1:0]     quot_q, quot_d;
    logic [DATA_W-1:0] den_q, den_d;
    logic [DATA_W:0]   rem_q, rem_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              dz_pend_q, dz_pend_d;   // zero-denominator flag of the op in flight
    logic              dz_q, dz_d;
    logic [QUOT_W-1:0] wt_q, wt_d;
    logic              ovr_q, ovr_d;

    logic [DATA_W:0]   rem_shift;
    logic              fits;
    logic [NW-1:0]     quot_next;

    always_comb begin
        rem_shift = {rem_q[DATA_W-1:0], num_q[NW-1]};
        fits      = rem_shift >= {1'b0, den_q};
        quot_next = {quot_q[NW-2:0], fits};

        state_d   = state_q;
        num_d     = num_q;
        quot_d    = quot_q;
        den_d     = den_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        dz_pend_d = dz_pend_q;
        dz_d      = dz_q;
        wt_d      = wt_q;
        ovr_d     = ovr_q;

        unique case (state_q)
            StIdle: begin
                if (sc_mem_rd_data_rdy) begin
                    num_d     = NW'(sc_mem_rd_data1) * ScaleExt;
                    den_d     = sc_mem_rd_data2;
                    rem_d     = '0;
                    quot_d    = '0;
                    cnt_d     = '0;
                    dz_pend_d = (sc_mem_rd_data2 == '0);
                    state_d   = StIter;
                end
            end
            StIter: begin
                rem_d  = fits ? (rem_shift - {1'b0, den_q}) : rem_shift;
                num_d  = num_q << 1;
                quot_d = quot_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    // Result registers are loaded from the final iteration so they
                    // are already valid in the DONE cycle.
                    state_d = StDone;
                    dz_d    = dz_pend_q;
                    if (dz_pend_q || (|quot_next[NW-1:QUOT_W])) begin
                        wt_d = '1;
                    end else begin
                        wt_d = quot_next[QUOT_W-1:0];
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (sc_mem_rd_data_rdy && (state_q != StIdle)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            num_q     <= '0;
            quot_q    <= '0;
            den_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            dz_pend_q <= 1'b0;
            dz_q      <= 1'b0;
            wt_q      <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            quot_q    <= quot_d;
            den_q     <= den_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            dz_pend_q <= dz_pend_d;
            dz_q      <= dz_d;
            wt_q      <= wt_d;
            ovr_q     <= ovr_d;
        end
    end

    assign div_done       = (state_q == StDone);
    assign div_busy       = (state_q != StIdle);
    assign sc_mem_wt_data = wt_q;
    assign div_by_zero    = dz_q;
    assign div_overrun    = ovr_q;

endmodule

// File: tb/tb_divider_core.sv
// Self-checking bench for divider_core: directed scenarios plus randomized
// operands checked against a plain-arithmetic reference model.
module tb_divider_core;

    localparam int unsigned Latency = 25;   // strobe cycle to div_done cycle

    logic        clk;
    logic        reset;
    logic        rdy;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        div_done;
    logic [7:0]  wt_data;
    logic        div_busy;
    logic        div_by_zero;
    logic        div_overrun;

    int n_checks = 0;
    int n_errors = 0;

    divider_core dut (
        .clk                (clk),
        .reset              (reset),
        .sc_mem_rd_data_rdy (rdy),
        .sc_mem_rd_data1    (d1),
        .sc_mem_rd_data2    (d2),
        .div_done           (div_done),
        .sc_mem_wt_data     (wt_data),
        .div_busy           (div_busy),
        .div_by_zero        (div_by_zero),
        .div_overrun        (div_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // (a * 255) / b saturated to 8 bits; zero denominator gives all ones.
    function automatic logic [7:0] model_q(input int unsigned a, input int unsigned b);
        longint unsigned q;
        if (b == 0) return 8'hff;
        q = (64'(a) * 64'd255) / 64'(b);
        if (q > 64'd255) return 8'hff;
        return q[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Strobe one operation (called in an IDLE cycle) and wait for its result.
    task automatic run_op(input string tag, input int unsigned a, input int unsigned b,
                          input logic exp_ovr);
        int  k;
        logic busy_ok;
        int  guard;
        guard = 0;
        while (div_busy && guard < 40) begin
            tick();
            guard++;
        end
        check({tag, " idle_done"}, div_done, 1'b0);
        rdy = 1'b1;
        d1  = a[15:0];
        d2  = b[15:0];
        tick();
        rdy = 1'b0;
        d1  = '0;
        d2  = '0;
        k = 0;
        busy_ok = 1'b1;
        while (!div_done && k < 40) begin
            if (!div_busy) busy_ok = 1'b0;
            tick();
            k++;
        end
        check({tag, " latency"}, k + 1, Latency);
        check({tag, " busy"}, {busy_ok, div_busy}, 2'b11);
        check({tag, " wt_data"}, wt_data, model_q(a, b));
        check({tag, " dz"}, div_by_zero, (b == 0));
        check({tag, " ovr"}, div_overrun, exp_ovr);
    endtask

    initial begin
        int dones;
        logic quiet_ok;
        reset = 1'b0;
        rdy   = 1'b0;
        d1    = '0;
        d2    = '0;
        #1;
        do_reset();

        // Quiet period after reset.
        quiet_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if ({div_done, wt_data, div_busy, div_by_zero, div_overrun} != '0) quiet_ok = 1'b0;
            tick();
        end
        check("reset_quiet", quiet_ok, 1'b1);
        check("reset_wt", wt_data, 8'd0);

        run_op("op100_200", 100, 200, 1'b0);
        check("op100_200 val", wt_data, 8'd127);
        run_op("op200_100", 200, 100, 1'b0);
        check("op200_100 val", wt_data, 8'd255);
        run_op("op5_0", 5, 0, 1'b0);
        run_op("op1_1", 1, 1, 1'b0);      // immediately after DONE, clears dz
        check("op1_1 dz_clear", div_by_zero, 1'b0);

        // Overrun: second strobe 5 cycles after the first is ignored.
        tick();
        rdy = 1'b1; d1 = 16'd10; d2 = 16'd10;
        tick();
        rdy = 1'b0;
        repeat (4) tick();
        rdy = 1'b1; d1 = 16'd20; d2 = 16'd1;
        tick();
        rdy = 1'b0; d1 = '0; d2 = '0;
        begin
            int k;
            k = 6;
            while (!div_done && k < 60) begin
                tick();
                k++;
            end
            check("ovr latency", k, Latency);
        end
        check("ovr wt_data", wt_data, 8'd255);
        check("ovr flag", div_overrun, 1'b1);
        dones = 0;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (div_done) dones++;
            tick();
        end
        check("ovr no_second_done", dones, 0);
        check("ovr held wt", wt_data, 8'd255);
        run_op("op3_255", 3, 255, 1'b1);

        // Reset in the middle of an operation.
        rdy = 1'b1; d1 = 16'd7; d2 = 16'd3;
        tick();
        rdy = 1'b0;
        repeat (12) tick();
        do_reset();
        check("abort outputs", {div_done, wt_data, div_busy, div_by_zero, div_overrun}, '0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (div_done) dones++;
            tick();
        end
        check("abort no_done", dones, 0);
        run_op("op1000_1000", 1000, 1000, 1'b0);

        // Randomized operands with a mix of small, large and zero denominators.
        for (int i = 0; i < 20; i++) begin
            int unsigned a;
            int unsigned b;
            a = $urandom_range(0, 65535);
            case ($urandom_range(0, 3))
                0:       b = 0;
                1:       b = $urandom_range(1, 255);
                2:       b = $urandom_range(256, 65535);
                default: b = a + $urandom_range(0, 100);
            endcase
            if (b > 65535) b = 65535;
            run_op("rand", a, b, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
